// File: rtl/pe_array_fusion_param_if.sv
// Handshake and operand bundle between a tile producer and the fusion PE array.
interface pe_array_fusion_param_if #(
    parameter int N_ROW     = 16,
    parameter int BITS_PSUM = 24,
    parameter int N_BIAS    = 16
);
    logic                        i_Valid;
    logic                        o_Ready;
    logic                        i_First;
    logic                        i_Last;
    logic [2*N_ROW-1:0]          i_Act;
    logic [2*N_ROW-1:0]          i_Weight;
    logic [3:0]                  i_Precision;
    logic                        i_SignA;
    logic signed [N_BIAS-1:0]    i_Bias;
    logic                        i_Flush;
    logic signed [BITS_PSUM-1:0] o_Psum;
    logic                        o_Valid;
    logic                        i_Ready;
    logic                        o_Err;
    logic                        o_Ovf;

    modport master (
        output i_Valid, i_First, i_Last, i_Act, i_Weight, i_Precision,
               i_SignA, i_Bias, i_Flush, i_Ready,
        input  o_Ready, o_Psum, o_Valid, o_Err, o_Ovf
    );

    modport slave (
        input  i_Valid, i_First, i_Last, i_Act, i_Weight, i_Precision,
               i_SignA, i_Bias, i_Flush, i_Ready,
        output o_Ready, o_Psum, o_Valid, o_Err, o_Ovf
    );
endinterface

// File: rtl/pe_array_fusion_param.sv
// Bit-brick fusion PE array: 2/4/8-bit dot products accumulated per tile with bias.
// Optional macro PE_ARRAY_SAT_EN selects a saturating accumulator with a sticky overflow flag.
module pe_array_fusion_param #(
    parameter int N_ROW     = 16,
    parameter int BITS_PSUM = 24,
    parameter int N_BIAS    = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    pe_array_fusion_param_if.slave bus
);
    localparam int SUM_W = 18 + $clog2(N_ROW);
    localparam int ACC_W = ((BITS_PSUM > SUM_W) ? BITS_PSUM : SUM_W) + 2;
    localparam int AW    = 2 * N_ROW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Widen a 2/4/8-bit operand field to 9-bit signed, honouring signedness.
    function automatic logic signed [8:0] ext_field(input logic [7:0] f,
                                                    input logic [1:0] code,
                                                    input logic       sgn);
        logic signed [8:0] r;
        case (code)
            2'b01:   r = {((sgn & f[3]) ? 5'h1F : 5'h00), f[3:0]};
            2'b10:   r = {(sgn & f[7]), f};
            default: r = {((sgn & f[1]) ? 7'h7F : 7'h00), f[1:0]};
        endcase
        return r;
    endfunction

    // Exact signed dot product of the elements active in this precision mode.
    function automatic logic signed [SUM_W-1:0] beat_sum(input logic [AW-1:0] act,
                                                         input logic [AW-1:0] wgt,
                                                         input logic [1:0]    ca,
                                                         input logic [1:0]    cw,
                                                         input logic          sgn);
        logic signed [SUM_W-1:0] acc;
        logic [AW-1:0]           a_sh;
        logic [AW-1:0]           w_sh;
        logic signed [17:0]      prod;
        int                      pa;
        int                      pw;
        int                      n_el;
        acc  = '0;
        pa   = 2 << int'(ca);
        pw   = 2 << int'(cw);
        n_el = N_ROW >> (int'(ca) + int'(cw));
        for (int k = 0; k < N_ROW; k++) begin
            a_sh = act >> (pa * k);
            w_sh = wgt >> (pw * k);
            prod = ext_field(a_sh[7:0], ca, sgn) * ext_field(w_sh[7:0], cw, 1'b1);
            if (k < n_el) begin
                acc = acc + SUM_W'(prod);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic                    drain_cnt_r;
    logic                    ready_s;
    logic                    accept_s;
    logic                    first_s;
    logic                    drop_s;
    logic                    load_s;
    logic                    bad_code_s;
    logic                    err_s;
    logic                    valid_s;
    logic [1:0]              code_a_s;
    logic [1:0]              code_w_s;
    logic [1:0]              eff_a_s;
    logic [1:0]              eff_w_s;
    logic                    eff_sgn_s;
    logic [3:0]              prec_r;
    logic                    sign_r;
    logic                    valid_r;
    logic                    err_r;

    logic                    s0_vld_r;
    logic [AW-1:0]           s0_act_r;
    logic [AW-1:0]           s0_wgt_r;
    logic [1:0]              s0_ca_r;
    logic [1:0]              s0_cw_r;
    logic                    s0_sgn_r;
    logic                    s0_first_r;
    logic signed [N_BIAS-1:0] s0_bias_r;

    logic                    s1_vld_r;
    logic signed [SUM_W-1:0] s1_psum_r;
    logic                    s1_first_r;
    logic signed [N_BIAS-1:0] s1_bias_r;

    logic signed [ACC_W-1:0]     base_s;
    logic signed [ACC_W-1:0]     sum_s;
    logic signed [BITS_PSUM-1:0] acc_r;
    logic signed [BITS_PSUM-1:0] acc_nxt_s;

    // Handshake decode: acceptance, error sources and per-beat effective precision.
    always_comb begin
        ready_s = 1'b0;
        if (bus.i_Flush) begin
            ready_s = 1'b0;
        end else if ((state_r == ST_IDLE) || (state_r == ST_ACCUM)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s   = bus.i_Valid && ready_s;
        first_s    = accept_s && bus.i_First;
        drop_s     = accept_s && !bus.i_First && (state_r == ST_IDLE);
        load_s     = accept_s && !drop_s;
        code_a_s   = (bus.i_Precision[3:2] == 2'b11) ? 2'b00 : bus.i_Precision[3:2];
        code_w_s   = (bus.i_Precision[1:0] == 2'b11) ? 2'b00 : bus.i_Precision[1:0];
        bad_code_s = first_s && ((bus.i_Precision[3:2] == 2'b11) ||
                                 (bus.i_Precision[1:0] == 2'b11));
        err_s      = drop_s || bad_code_s || (first_s && (state_r == ST_ACCUM));
        if (first_s) begin
            eff_a_s   = code_a_s;
            eff_w_s   = code_w_s;
            eff_sgn_s = bus.i_SignA;
        end else begin
            eff_a_s   = prec_r[3:2];
            eff_w_s   = prec_r[1:0];
            eff_sgn_s = sign_r;
        end
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_s = state_r;
        if (bus.i_Flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (first_s) begin
                        state_s = bus.i_Last ? ST_DRAIN : ST_ACCUM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s && bus.i_Last) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_ACCUM;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_Ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: result valid follows entry into HOLD.
    always_comb begin
        valid_s = (state_s == ST_HOLD);
    end

    // State register, two-cycle drain counter and registered status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= 1'b0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            drain_cnt_r <= ((state_r == ST_DRAIN) && !bus.i_Flush) ? ~drain_cnt_r : 1'b0;
            valid_r     <= valid_s;
            err_r       <= err_s;
        end
    end

    // Tile-wide precision and signedness, captured on each accepted first beat.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prec_r <= 4'b0000;
            sign_r <= 1'b0;
        end else if (first_s) begin
            prec_r <= {code_a_s, code_w_s};
            sign_r <= bus.i_SignA;
        end else begin
            prec_r <= prec_r;
            sign_r <= sign_r;
        end
    end

    // Input register: accepted beat with its effective mode.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0_vld_r   <= 1'b0;
            s0_act_r   <= '0;
            s0_wgt_r   <= '0;
            s0_ca_r    <= 2'b00;
            s0_cw_r    <= 2'b00;
            s0_sgn_r   <= 1'b0;
            s0_first_r <= 1'b0;
            s0_bias_r  <= '0;
        end else if (bus.i_Flush) begin
            s0_vld_r   <= 1'b0;
        end else begin
            s0_vld_r <= load_s;
            if (load_s) begin
                s0_act_r   <= bus.i_Act;
                s0_wgt_r   <= bus.i_Weight;
                s0_ca_r    <= eff_a_s;
                s0_cw_r    <= eff_w_s;
                s0_sgn_r   <= eff_sgn_s;
                s0_first_r <= bus.i_First;
                s0_bias_r  <= bus.i_Bias;
            end else begin
                s0_act_r   <= s0_act_r;
            end
        end
    end

    // Stage 1: beat partial sum.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_vld_r   <= 1'b0;
            s1_psum_r  <= '0;
            s1_first_r <= 1'b0;
            s1_bias_r  <= '0;
        end else if (bus.i_Flush) begin
            s1_vld_r   <= 1'b0;
        end else begin
            s1_vld_r <= s0_vld_r;
            if (s0_vld_r) begin
                s1_psum_r  <= beat_sum(s0_act_r, s0_wgt_r, s0_ca_r, s0_cw_r, s0_sgn_r);
                s1_first_r <= s0_first_r;
                s1_bias_r  <= s0_bias_r;
            end else begin
                s1_psum_r  <= s1_psum_r;
            end
        end
    end

`ifdef PE_ARRAY_SAT_EN
    localparam logic signed [BITS_PSUM-1:0] PSUM_MAX = {1'b0, {(BITS_PSUM-1){1'b1}}};
    localparam logic signed [BITS_PSUM-1:0] PSUM_MIN = {1'b1, {(BITS_PSUM-1){1'b0}}};
    logic clamp_s;
    logic ovf_r;

    // Stage 2 arithmetic, clamped to the signed output range.
    always_comb begin
        base_s  = s1_first_r ? ACC_W'(s1_bias_r) : ACC_W'(acc_r);
        sum_s   = base_s + ACC_W'(s1_psum_r);
        clamp_s = 1'b0;
        if (sum_s > ACC_W'(PSUM_MAX)) begin
            acc_nxt_s = PSUM_MAX;
            clamp_s   = 1'b1;
        end else if (sum_s < ACC_W'(PSUM_MIN)) begin
            acc_nxt_s = PSUM_MIN;
            clamp_s   = 1'b1;
        end else begin
            acc_nxt_s = BITS_PSUM'(sum_s);
        end
    end

    // Sticky overflow; only the asynchronous reset clears it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_r <= 1'b0;
        end else if (s1_vld_r && clamp_s && !bus.i_Flush) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.o_Ovf = ovf_r;
`else
    // Stage 2 arithmetic, wrapping modulo 2^BITS_PSUM.
    always_comb begin
        base_s    = s1_first_r ? ACC_W'(s1_bias_r) : ACC_W'(acc_r);
        sum_s     = base_s + ACC_W'(s1_psum_r);
        acc_nxt_s = BITS_PSUM'(sum_s);
    end

    assign bus.o_Ovf = 1'b0;
`endif

    // Stage 2: accumulator, which is also the result register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_r <= '0;
        end else if (bus.i_Flush) begin
            acc_r <= '0;
        end else if (s1_vld_r) begin
            acc_r <= acc_nxt_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign bus.o_Ready = ready_s;
    assign bus.o_Psum  = acc_r;
    assign bus.o_Valid = valid_r;
    assign bus.o_Err   = err_r;
endmodule

// File: tb/tb_pe_array_fusion_param.sv
// Directed bench for pe_array_fusion_param: a 24-bit instance plus a 16-bit mirror for overflow.
module tb_pe_array_fusion_param;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    pe_array_fusion_param_if #(.N_ROW(16), .BITS_PSUM(24), .N_BIAS(16)) bus ();
    pe_array_fusion_param_if #(.N_ROW(16), .BITS_PSUM(16), .N_BIAS(16)) bus2 ();

    pe_array_fusion_param #(.N_ROW(16), .BITS_PSUM(24), .N_BIAS(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave));
    pe_array_fusion_param #(.N_ROW(16), .BITS_PSUM(16), .N_BIAS(16)) dut16 (
        .CLK(CLK), .RST(RST), .bus(bus2.slave));

    assign bus2.i_Valid     = bus.i_Valid;
    assign bus2.i_First     = bus.i_First;
    assign bus2.i_Last      = bus.i_Last;
    assign bus2.i_Act       = bus.i_Act;
    assign bus2.i_Weight    = bus.i_Weight;
    assign bus2.i_Precision = bus.i_Precision;
    assign bus2.i_SignA     = bus.i_SignA;
    assign bus2.i_Bias      = bus.i_Bias;
    assign bus2.i_Flush     = bus.i_Flush;
    assign bus2.i_Ready     = bus.i_Ready;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one beat; returns 1 time unit after its accepting edge.
    task automatic beat(input logic first, input logic last, input logic [31:0] act,
                        input logic [31:0] wgt, input logic [3:0] prec, input logic sa,
                        input logic signed [15:0] bias);
        bus.i_Valid     = 1'b1;
        bus.i_First     = first;
        bus.i_Last      = last;
        bus.i_Act       = act;
        bus.i_Weight    = wgt;
        bus.i_Precision = prec;
        bus.i_SignA     = sa;
        bus.i_Bias      = bias;
        tick();
        bus.i_Valid = 1'b0;
        bus.i_First = 1'b0;
        bus.i_Last  = 1'b0;
    endtask

    task automatic consume();
        bus.i_Ready = 1'b1;
        tick();
        bus.i_Ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b0;
        bus.i_Valid = 1'b0; bus.i_First = 1'b0; bus.i_Last = 1'b0;
        bus.i_Act = 32'h0; bus.i_Weight = 32'h0; bus.i_Precision = 4'h0;
        bus.i_SignA = 1'b0; bus.i_Bias = 16'sh0; bus.i_Flush = 1'b0; bus.i_Ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.o_Valid, 0);
        check("rst_psum", bus.o_Psum, 0);
        check("rst_err", bus.o_Err, 0);
        check("rst_ovf", bus2.o_Ovf, 0);
        RST = 1'b1;
        tick();
        check("rst_ready", bus.o_Ready, 1);

        // 2x2 unsigned: 16 x (1*1) + 5
        beat(1'b1, 1'b1, 32'h5555_5555, 32'h5555_5555, 4'b0000, 1'b0, 16'sd5);
        check("m22_drain_ready", bus.o_Ready, 0);
        tick();
        check("m22_valid_early", bus.o_Valid, 0);
        tick();
        check("m22_valid", bus.o_Valid, 1);
        check("m22_psum", bus.o_Psum, 21);
        consume();
        check("m22_valid_drop", bus.o_Valid, 0);
        check("m22_ready_back", bus.o_Ready, 1);

        // 8x8: 255 * -128, upper operand bits are junk
        beat(1'b1, 1'b1, 32'hABCD_12FF, 32'h5A5A_0080, 4'b1010, 1'b0, 16'sd0);
        tick(); tick();
        check("m88_valid", bus.o_Valid, 1);
        check("m88_psum", bus.o_Psum, -32640);
        consume();

        // 4x2 three-beat tile; the middle beat's mode fields must be ignored
        beat(1'b1, 1'b0, 32'h3111_1111, 32'hFFFF_5555, 4'b0100, 1'b0, -16'sd4);
        beat(1'b0, 1'b0, 32'h0000_005F, 32'h0000_000D, 4'b1010, 1'b1, 16'sd77);
        beat(1'b0, 1'b1, 32'h3111_1111, 32'hFFFF_5555, 4'b0100, 1'b0, 16'sd0);
        check("m42_drain_ready", bus.o_Ready, 0);
        tick();
        check("m42_valid_early", bus.o_Valid, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("m42_hold_valid", bus.o_Valid, 1);
            check("m42_hold_psum", bus.o_Psum, 26);
            check("m42_hold_ready", bus.o_Ready, 0);
            tick();
        end
        consume();
        check("m42_valid_drop", bus.o_Valid, 0);

        // Beat without first marker in IDLE is dropped
        beat(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1'b0, 16'sd0);
        check("drop_err", bus.o_Err, 1);
        tick();
        check("drop_err_clear", bus.o_Err, 0);
        check("drop_ready", bus.o_Ready, 1);
        tick(); tick();
        check("drop_no_valid", bus.o_Valid, 0);

        // Flush mid-tile
        beat(1'b1, 1'b0, 32'h5555_5555, 32'h5555_5555, 4'b0000, 1'b0, 16'sd7);
        bus.i_Flush = 1'b1;
        #1;
        check("flush_ready", bus.o_Ready, 0);
        @(posedge CLK); #1;
        bus.i_Flush = 1'b0;
        #1;
        check("flush_ready_after", bus.o_Ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_valid", bus.o_Valid, 0);
        end
        check("flush_psum", bus.o_Psum, 0);

        // 2x4 signed activations after the flush: 8 x (-1*3) + 100
        beat(1'b1, 1'b1, 32'h1234_FFFF, 32'h3333_3333, 4'b0001, 1'b1, 16'sd100);
        tick(); tick();
        check("m24_valid", bus.o_Valid, 1);
        check("m24_psum", bus.o_Psum, 76);
        consume();

        // Illegal act code falls back to 2b and flags an error
        beat(1'b1, 1'b1, 32'h5555_5555, 32'hFFFF_FFFF, 4'b1100, 1'b0, 16'sd0);
        check("illegal_err", bus.o_Err, 1);
        tick();
        check("illegal_err_clear", bus.o_Err, 0);
        tick();
        check("illegal_psum", bus.o_Psum, -16);
        consume();

        // Two 8x8 beats of 255*127 overflow the 16-bit instance
        beat(1'b1, 1'b0, 32'h0000_00FF, 32'h0000_007F, 4'b1010, 1'b0, 16'sd0);
        beat(1'b0, 1'b1, 32'h0000_00FF, 32'h0000_007F, 4'b1010, 1'b0, 16'sd0);
        tick(); tick();
        check("ovf24_psum", bus.o_Psum, 64770);
        check("ovf24_flag", bus.o_Ovf, 0);
        check("ovf16_valid", bus2.o_Valid, 1);
`ifdef PE_ARRAY_SAT_EN
        check("ovf16_psum", bus2.o_Psum, 32767);
        check("ovf16_flag", bus2.o_Ovf, 1);
`else
        check("ovf16_psum", bus2.o_Psum, -766);
        check("ovf16_flag", bus2.o_Ovf, 0);
`endif
        consume();

        // Reset during DRAIN discards the tile
        beat(1'b1, 1'b1, 32'h5555_5555, 32'h5555_5555, 4'b0000, 1'b0, 16'sd5);
        tick();
        RST = 1'b0;
        #1;
        check("rstd_valid", bus.o_Valid, 0);
        check("rstd_psum", bus.o_Psum, 0);
        check("rstd_err", bus.o_Err, 0);
        check("rstd_ovf", bus2.o_Ovf, 0);
        check("rstd_psum16", bus2.o_Psum, 0);
        tick(); tick();
        RST = 1'b1;
        #1;
        check("rstd_ready", bus.o_Ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstd_no_valid", bus.o_Valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
